// File: rtl/bsg_xor_checksum_arb.sv
// Round-robin shared XOR checksum engine: one requester owns the datapath for a
// whole packet, then checksum, owner id and saturating word count are offered downstream.
module bsg_xor_checksum_arb
  #(parameter  int width_p       = 32
   ,parameter  int els_p         = 4
   ,parameter  int count_width_p = 8
   ,localparam int lg_els_lp     = $clog2(els_p))
   (input  logic                         clk_i
   ,input  logic                         reset_n_i
   ,input  logic [els_p-1:0]             v_i
   ,input  logic [els_p*width_p-1:0]     data_i
   ,input  logic [els_p-1:0]             last_i
   ,output logic [els_p-1:0]             yumi_o
   ,output logic                         v_o
   ,output logic [width_p-1:0]           data_o
   ,output logic [lg_els_lp-1:0]         id_o
   ,output logic [count_width_p-1:0]     count_o
   ,input  logic                         ready_i
   );

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]               state_r, state_n_s;
   logic [width_p-1:0]       acc_r;
   logic [count_width_p-1:0] cnt_r, cnt_inc_s;
   logic [lg_els_lp-1:0]     grant_r, last_grant_r, winner_s;
   logic                     any_v_s, v_r;
   logic [els_p-1:0]         yumi_s;
   logic [width_p-1:0]       win_data_s, gnt_data_s;

   // round-robin search starting just after the previous owner
   always_comb begin
      int idx;
      idx      = 0;
      winner_s = '0;
      any_v_s  = 1'b0;
      for (int i = 1; i <= els_p; i++) begin
         idx = (int'(last_grant_r) + i) % els_p;
         if (!any_v_s && v_i[idx]) begin
            any_v_s  = 1'b1;
            winner_s = lg_els_lp'(idx);
         end else begin
            any_v_s  = any_v_s;
         end
      end
   end

   assign win_data_s = data_i[int'(winner_s)*width_p +: width_p];
   assign gnt_data_s = data_i[int'(grant_r)*width_p +: width_p];
   assign cnt_inc_s  = (cnt_r == {count_width_p{1'b1}}) ? cnt_r : cnt_r + count_width_p'(1);

   // consume strobe: only the winner in IDLE, only the owner in BUSY
   always_comb begin
      yumi_s = '0;
      case (state_r)
         IDLE: begin
            if (any_v_s) yumi_s[winner_s] = 1'b1;
            else         yumi_s = '0;
         end
         BUSY:    yumi_s[grant_r] = v_i[grant_r];
         default: yumi_s = '0;
      endcase
   end

   // yumi is gated by reset so nothing is consumed while the block is held in reset
   assign yumi_o = yumi_s & {els_p{reset_n_i}};

   // next-state decode
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_v_s) state_n_s = last_i[winner_s] ? DONE : BUSY;
            else         state_n_s = IDLE;
         end
         BUSY: begin
            if (v_i[grant_r] && last_i[grant_r]) state_n_s = DONE;
            else                                 state_n_s = BUSY;
         end
         DONE: begin
            if (ready_i) state_n_s = IDLE;
            else         state_n_s = DONE;
         end
         default: state_n_s = IDLE;
      endcase
   end

   // datapath, arbitration pointer and registered result valid
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r      <= IDLE;
         acc_r        <= '0;
         cnt_r        <= '0;
         grant_r      <= '0;
         last_grant_r <= lg_els_lp'(els_p-1);
         v_r          <= 1'b0;
      end else begin
         state_r <= state_n_s;
         v_r     <= (state_n_s == DONE);
         case (state_r)
            IDLE: begin
               if (any_v_s) begin
                  grant_r <= winner_s;
                  acc_r   <= win_data_s;
                  cnt_r   <= count_width_p'(1);
               end
            end
            BUSY: begin
               if (v_i[grant_r]) begin
                  acc_r <= acc_r ^ gnt_data_s;
                  cnt_r <= cnt_inc_s;
               end
            end
            DONE: begin
               if (ready_i) last_grant_r <= grant_r;
            end
            default: ;
         endcase
      end
   end

   assign v_o     = v_r;
   assign data_o  = acc_r;
   assign id_o    = grant_r;
   assign count_o = cnt_r;

endmodule

// File: tb/tb_bsg_xor_checksum_arb.sv
// Directed bench for bsg_xor_checksum_arb; a second instance with a 2-bit count
// shares the stimulus and is checked for count saturation.
module tb_bsg_xor_checksum_arb;

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic [3:0]    v_i, last_i, yumi_o, yumi2;
   logic [127:0]  data_i;
   logic          v_o, v2, ready_i;
   logic [31:0]   data_o, d2;
   logic [1:0]    id_o, id2;
   logic [7:0]    count_o;
   logic [1:0]    cnt2;
   int            pass_cnt = 0;
   int            total_cnt = 0;

   always #5 clk = ~clk;

   bsg_xor_checksum_arb #(.width_p(32), .els_p(4), .count_width_p(8)) dut
     (.clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
      .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .id_o(id_o), .count_o(count_o),
      .ready_i(ready_i));

   bsg_xor_checksum_arb #(.width_p(32), .els_p(4), .count_width_p(2)) dut2
     (.clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
      .yumi_o(yumi2), .v_o(v2), .data_o(d2), .id_o(id2), .count_o(cnt2),
      .ready_i(ready_i));

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step();
      reset_n_i = 1'b0; v_i = 4'b0000; last_i = 4'b0000; ready_i = 1'b0; data_i = '0;
      step();
      step();
      reset_n_i = 1'b1;
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0; v_i = 4'b1111; last_i = 4'b1111; ready_i = 1'b1; data_i = '1;
      step(); step(); #1;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL reset_v: got %b exp 0", v_o); else pass_cnt++;
      total_cnt++; if (yumi_o !== 4'b0000) $display("FAIL reset_yumi: got %b exp 0000", yumi_o); else pass_cnt++;
      total_cnt++; if (data_o !== 32'h0 || id_o !== 2'd0 || count_o !== 8'd0)
         $display("FAIL reset_outs: got %h/%0d/%0d exp 0/0/0", data_o, id_o, count_o); else pass_cnt++;
      v_i = 4'b0000; last_i = 4'b0000; ready_i = 1'b0; data_i = '0;
      step();
      reset_n_i = 1'b1;
   endtask

   task automatic test_single();
      step();
      v_i = 4'b0001; last_i = 4'b0001; data_i[31:0] = 32'hDEADBEEF; ready_i = 1'b1; #1;
      total_cnt++; if (yumi_o !== 4'b0001) $display("FAIL single_yumi: got %b exp 0001", yumi_o); else pass_cnt++;
      step();
      v_i = 4'b0000; last_i = 4'b0000; #1;
      total_cnt++; if (v_o !== 1'b1 || data_o !== 32'hDEADBEEF || id_o !== 2'd0 || count_o !== 8'd1)
         $display("FAIL single_result: got v=%b %h id=%0d cnt=%0d exp v=1 deadbeef id=0 cnt=1",
                  v_o, data_o, id_o, count_o); else pass_cnt++;
      step(); #1;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL single_accept: got v=%b exp 0", v_o); else pass_cnt++;
   endtask

   task automatic test_bubble();
      logic [31:0] w [3];
      logic [3:0]  vv [4];
      w[0] = 32'h0000FFFF; w[1] = 32'hFFFF0000; w[2] = 32'h12345678;
      vv[0] = 4'b0100; vv[1] = 4'b0000; vv[2] = 4'b0100; vv[3] = 4'b0100;
      ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         v_i = vv[c];
         data_i[95:64] = (c == 0) ? w[0] : (c == 2) ? w[1] : w[2];
         last_i = (c == 3) ? 4'b0100 : 4'b0000;
         #1;
         total_cnt++; if (yumi_o !== vv[c]) $display("FAIL bubble_yumi%0d: got %b exp %b", c, yumi_o, vv[c]); else pass_cnt++;
      end
      step();
      v_i = 4'b0000; last_i = 4'b0000; #1;
      total_cnt++; if (v_o !== 1'b1 || data_o !== 32'hEDCBA987 || id_o !== 2'd2 || count_o !== 8'd3)
         $display("FAIL bubble_result: got v=%b %h id=%0d cnt=%0d exp v=1 edcba987 id=2 cnt=3",
                  v_o, data_o, id_o, count_o); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int exp_id [5];
      exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 2; exp_id[3] = 3; exp_id[4] = 0;
      do_reset();
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = 32'(k + 1);
      for (int p = 0; p < 5; p++) begin
         step();
         v_i = 4'b1111; last_i = 4'b1111; #1;
         total_cnt++; if (yumi_o !== (4'b0001 << exp_id[p]) || !$onehot0(yumi_o))
            $display("FAIL rr_yumi%0d: got %b exp %b", p, yumi_o, 4'b0001 << exp_id[p]); else pass_cnt++;
         step(); #1;
         total_cnt++; if (v_o !== 1'b1 || id_o !== 2'(exp_id[p]) || data_o !== 32'(exp_id[p] + 1) || yumi_o !== 4'b0000)
            $display("FAIL rr_result%0d: got v=%b id=%0d %h yumi=%b exp v=1 id=%0d %0d yumi=0000",
                     p, v_o, id_o, data_o, yumi_o, exp_id[p], exp_id[p] + 1); else pass_cnt++;
      end
      v_i = 4'b0000; last_i = 4'b0000;
   endtask

   task automatic test_packet_lock();
      logic [3:0] vv [5];
      logic [3:0] ey [5];
      vv[0] = 4'b0010; vv[1] = 4'b1011; vv[2] = 4'b1001; vv[3] = 4'b1011; vv[4] = 4'b1001;
      ey[0] = 4'b0010; ey[1] = 4'b0010; ey[2] = 4'b0000; ey[3] = 4'b0010; ey[4] = 4'b0000;
      step();
      ready_i = 1'b0;
      data_i[31:0] = 32'hAAAA0000; data_i[127:96] = 32'h0000BBBB;
      for (int c = 0; c < 5; c++) begin
         v_i = vv[c];
         last_i = (c == 3) ? 4'b1011 : 4'b1001;
         data_i[63:32] = 32'h1 << c;
         #1;
         total_cnt++; if (yumi_o !== ey[c]) $display("FAIL lock_yumi%0d: got %b exp %b", c, yumi_o, ey[c]); else pass_cnt++;
         step();
      end
      // still in DONE: words 1, 2 and 8 were taken
      ready_i = 1'b1; #1;
      total_cnt++; if (v_o !== 1'b1 || id_o !== 2'd1 || count_o !== 8'd3 || data_o !== 32'h0000000B || yumi_o !== 4'b0000)
         $display("FAIL lock_result: got v=%b id=%0d cnt=%0d %h yumi=%b exp v=1 id=1 cnt=3 0000000b yumi=0000",
                  v_o, id_o, count_o, data_o, yumi_o); else pass_cnt++;
      step(); #1;
      total_cnt++; if (yumi_o !== 4'b1000) $display("FAIL lock_next_grant: got %b exp 1000", yumi_o); else pass_cnt++;
      step();
      v_i = 4'b0000; last_i = 4'b0000; #1;
      total_cnt++; if (v_o !== 1'b1 || id_o !== 2'd3 || data_o !== 32'h0000BBBB)
         $display("FAIL lock_r3_result: got v=%b id=%0d %h exp v=1 id=3 0000bbbb", v_o, id_o, data_o); else pass_cnt++;
      step();
   endtask

   task automatic test_backpressure();
      ready_i = 1'b0;
      v_i = 4'b0001; last_i = 4'b0000; data_i[31:0] = 32'h11110000;
      step();
      last_i = 4'b0001; data_i[31:0] = 32'h00002222;
      step();
      last_i = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         #1;
         total_cnt++; if (v_o !== 1'b1 || data_o !== 32'h11112222 || id_o !== 2'd0 || count_o !== 8'd2 || yumi_o !== 4'b0000)
            $display("FAIL bp_hold%0d: got v=%b %h id=%0d cnt=%0d yumi=%b exp v=1 11112222 id=0 cnt=2 yumi=0000",
                     c, v_o, data_o, id_o, count_o, yumi_o); else pass_cnt++;
         step();
      end
      ready_i = 1'b1; #1;
      total_cnt++; if (v_o !== 1'b1) $display("FAIL bp_last_hold: got v=%b exp 1", v_o); else pass_cnt++;
      step();
      last_i = 4'b0001; data_i[31:0] = 32'h00000042; #1;
      total_cnt++; if (v_o !== 1'b0 || yumi_o !== 4'b0001)
         $display("FAIL bp_idle_next: got v=%b yumi=%b exp v=0 yumi=0001", v_o, yumi_o); else pass_cnt++;
      step();
      v_i = 4'b0000; last_i = 4'b0000;
      step();
   endtask

   task automatic test_saturation_reset();
      do_reset();
      ready_i = 1'b0;
      data_i[31:0] = 32'h1;
      for (int c = 0; c < 5; c++) begin
         step();
         v_i = 4'b0001; last_i = (c == 4) ? 4'b0001 : 4'b0000;
      end
      step();
      v_i = 4'b0000; last_i = 4'b0000; #1;
      total_cnt++; if (v2 !== 1'b1 || cnt2 !== 2'd3 || d2 !== 32'h1)
         $display("FAIL sat_result: got v=%b cnt=%0d %h exp v=1 cnt=3 00000001", v2, cnt2, d2); else pass_cnt++;
      total_cnt++; if (count_o !== 8'd5) $display("FAIL sat_wide_count: got %0d exp 5", count_o); else pass_cnt++;
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      v_i = 4'b0100; last_i = 4'b0000; data_i[95:64] = 32'h5;
      step(); step();
      reset_n_i = 1'b0; #1;
      total_cnt++; if (yumi_o !== 4'b0000) $display("FAIL rst_mid_yumi: got %b exp 0000", yumi_o); else pass_cnt++;
      v_i = 4'b0100; last_i = 4'b0100;
      step(); #1;
      total_cnt++; if (v_o !== 1'b0 || yumi_o !== 4'b0000 || count_o !== 8'd0)
         $display("FAIL rst_mid_outs: got v=%b yumi=%b cnt=%0d exp v=0 yumi=0000 cnt=0", v_o, yumi_o, count_o); else pass_cnt++;
      reset_n_i = 1'b1;
      v_i = 4'b1111; last_i = 4'b1111; #1;
      total_cnt++; if (yumi_o !== 4'b0001) $display("FAIL rst_priority: got %b exp 0001", yumi_o); else pass_cnt++;
      step();
      v_i = 4'b0000; last_i = 4'b0000; ready_i = 1'b1; #1;
      total_cnt++; if (v_o !== 1'b1 || id_o !== 2'd0)
         $display("FAIL rst_first_result: got v=%b id=%0d exp v=1 id=0", v_o, id_o); else pass_cnt++;
      step();
   endtask

   initial begin
      reset_n_i = 1'b0; v_i = 4'b0000; last_i = 4'b0000; ready_i = 1'b0; data_i = '0;
      test_reset();
      test_single();
      test_bubble();
      test_round_robin();
      test_packet_lock();
      test_backpressure();
      test_saturation_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bsg_xor_checksum_arb.md
Name: bsg_xor_checksum_arb

Overview:
- Shares one width_p-bit XOR accumulate datapath among els_p requesters.
- Each requester streams a packet of words (valid/yumi, with a last flag). Arbitration is round-robin and holds one grant for a whole packet.
- The block folds each packet's words into a running XOR checksum, then emits checksum, requester id and word count over a valid/ready output.
- Sits between packet sources and the checksum/parity checking logic.

Parameters:
width_p, 32, data word and checksum width
els_p, 4, number of requesters (>=2)
count_width_p, 8, width of word-count output; count saturates at 2^count_width_p-1
lg_els_lp, $clog2(els_p), derived id width (localparam)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_n_i  input  1  synchronous, active-low reset
v_i  input  els_p  per-requester word valid
data_i  input  els_p*width_p  per-requester word; requester k uses bits [k*width_p +: width_p]
last_i  input  els_p  per-requester flag: this word ends the packet
yumi_o  output  els_p  per-requester consume strobe; one-hot or zero; combinational from v_i and state
v_o  output  1  checksum result valid
data_o  output  width_p  XOR of all words of the packet
id_o  output  lg_els_lp  requester index that owned the packet
count_o  output  count_width_p  words in the packet, saturating
ready_i  input  1  downstream accepts result when v_o & ready_i

Behaviour:
- Reset (reset_n_i==0 at clk edge):
  - state<=IDLE; acc<=0; cnt<=0; grant<=0; last_grant<=els_p-1, so requester 0 has first priority.
  - Outputs during and after reset: v_o=0, yumi_o=0, data_o=0, id_o=0, count_o=0.
  - Reset mid-packet or mid-DONE discards the partial or pending result. No output is produced for it.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Winner w = first k with v_i[k]=1, searching last_grant+1, last_grant+2, ... mod els_p.
  - If any v_i: yumi_o[w]=1 in the same cycle; grant<=w; acc<=data_i[w]; cnt<=1.
  - Next state: DONE if last_i[w], else BUSY.
  - No v_i: stay IDLE, yumi_o=0.
- BUSY:
  - yumi_o[grant]=v_i[grant]; all other yumi bits are 0.
  - Other requesters' v_i are ignored, even if asserted.
  - On v_i[grant]: acc<=acc^data_i[grant]; cnt<=sat(cnt+1).
  - If last_i[grant] is also set: go to DONE.
  - Cycles with v_i[grant]=0 are bubbles: no state change.
- DONE:
  - v_o=1; data_o=acc; id_o=grant; count_o=cnt; yumi_o=0.
  - Outputs are held stable until ready_i.
  - On ready_i: last_grant<=grant; state<=IDLE. The next grant is decided in the following cycle.
- Latency: a one-word packet is consumed in cycle N and has v_o=1 in N+1. An n-word packet with no bubbles has v_o in the cycle after its last word. Minimum per-packet occupancy is 2 cycles plus ready_i stall.
- Fairness: a requester that holds v_i is served within els_p-1 packets of others.
- Count saturates at 2^count_width_p-1 and never wraps. The XOR keeps accumulating past saturation.
- Outside DONE: v_o=0, and data_o/id_o/count_o hold their last values (implementation may drive registered values). The bench checks them only when v_o=1.
- last_i, data_i and v_i of non-granted requesters have no effect.
- Round-robin pointer wraps from els_p-1 to 0.

Test Plan:
- Reset then single-word packet: v_i=4'b0001, data_i[0]=32'hDEADBEEF, last_i[0]=1.
  - Response: yumi_o=4'b0001 same cycle.
  - Next cycle: v_o=1, data_o=32'hDEADBEEF, id_o=0, count_o=1.
- Three-word packet on requester 2 with a bubble: words 32'h0000FFFF, 32'hFFFF0000, 32'h12345678, with a one-cycle v_i[2]=0 gap.
  - Response: data_o=32'hEDCBA987, id_o=2, count_o=3.
  - yumi_o[2] only on valid cycles.
- Round-robin with all four requesters continuously valid, one-word packets, ready_i=1.
  - Response: id_o sequence 0,1,2,3,0; yumi_o never has more than one bit set.
- Packet lock: requester 1 is mid-packet while requesters 0 and 3 assert v_i.
  - Response: yumi_o[0] and yumi_o[3] stay 0 until requester 1's result is accepted.
  - Next grant is 3 (search from 2: requester 2 idle).
- Backpressure: hold ready_i=0 for 5 cycles in DONE.
  - Response: v_o, data_o, id_o and count_o are stable; yumi_o=0 throughout.
  - Accepted on the first cycle ready_i=1; IDLE next.
- Saturation and reset: with count_width_p=2, send a 5-word packet of 32'h1 each.
  - Response: count_o=3, data_o=32'h1.
  - Then assert reset_n_i=0 mid-packet: v_o=0 and yumi_o=0. After release, requester 0 has priority.
